exe_mem_pipe_reg: RTL and testbench



---
 rtl/exe_mem_pipe_reg_if.sv | 33 +++
 rtl/exe_mem_pipe_reg.sv | 93 +++++++++
 tb/tb_exe_mem_pipe_reg.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_mem_pipe_reg_if.sv
// rtl/exe_mem_pipe_reg_if.sv - EX/MEM pipeline register bus: EX-side inputs, hazard controls, MEM-side outputs
interface exe_mem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              e_valid;
  logic              ewreg;
  logic              em2reg;
  logic              ewmem;
  logic [REG_AW-1:0] edestReg;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] eqb;
  logic              stall;
  logic              flush;

  logic              m_valid;
  logic              mwreg;
  logic              mm2reg;
  logic              mwmem;
  logic [REG_AW-1:0] mdestReg;
  logic [DATA_W-1:0] mr;
  logic [DATA_W-1:0] mqb;

  modport master (
    output e_valid, ewreg, em2reg, ewmem, edestReg, r, eqb, stall, flush,
    input  m_valid, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
  );

  modport slave (
    input  e_valid, ewreg, em2reg, ewmem, edestReg, r, eqb, stall, flush,
    output m_valid, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
  );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// rtl/exe_mem_pipe_reg.sv - EX/MEM pipeline register with valid, stall/flush, $zero suppression, 1..4 stages
// Optional stall/bubble performance counters enabled by EXE_MEM_PERF_CNT_EN.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EXE_MEM_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  exe_mem_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] qb;
  } stage_t;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("exe_mem_pipe_reg: STAGES must be in 1..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("exe_mem_pipe_reg: CNT_W must be at least 1");
  end

  stage_t r_stage [STAGES];
  stage_t w_cap;

  // Control bits of a bubble are forced low; $zero is never a write target.
  always_comb begin
    w_cap       = '0;
    w_cap.valid = bus.e_valid;
    w_cap.wreg  = bus.e_valid && bus.ewreg && (bus.edestReg != '0);
    w_cap.m2reg = bus.e_valid && bus.em2reg;
    w_cap.wmem  = bus.e_valid && bus.ewmem;
    w_cap.dest  = bus.edestReg;
    w_cap.r     = bus.r;
    w_cap.qb    = bus.eqb;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else if (!bus.stall) begin
      r_stage[0] <= w_cap;
      for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign bus.m_valid  = r_stage[STAGES-1].valid;
  assign bus.mwreg    = r_stage[STAGES-1].wreg;
  assign bus.mm2reg   = r_stage[STAGES-1].m2reg;
  assign bus.mwmem    = r_stage[STAGES-1].wmem;
  assign bus.mdestReg = r_stage[STAGES-1].dest;
  assign bus.mr       = r_stage[STAGES-1].r;
  assign bus.mqb      = r_stage[STAGES-1].qb;

`ifdef EXE_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_stall_inc;
  logic             w_bubble_inc;

  assign w_stall_inc  = bus.stall && !bus.flush;
  assign w_bubble_inc = bus.flush || (!bus.stall && !bus.e_valid);

  // Saturating: counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_bubble_inc && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb/tb_exe_mem_pipe_reg.sv - scoreboard bench for exe_mem_pipe_reg with a queue-based reference model
module tb_exe_mem_pipe_reg;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int STAGES  = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_mem_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

`ifdef EXE_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  exe_mem_pipe_reg #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .STAGES(STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef EXE_MEM_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    bit              valid;
    bit              wreg;
    bit              m2reg;
    bit              wmem;
    bit [REG_AW-1:0] dest;
    bit [DATA_W-1:0] r;
    bit [DATA_W-1:0] qb;
    int              scnt;
    int              bcnt;
  } exp_t;

  exp_t pipe_m [$];
  exp_t exp_q  [$];
  int   model_scnt = 0;
  int   model_bcnt = 0;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t zero_entry();
    exp_t z;
    z = '{default: 0};
    return z;
  endfunction

  // One clock of stimulus; the model result for that edge goes to the scoreboard.
  task automatic drive(input bit rs, input bit v, input bit w, input bit m2, input bit wm,
                       input bit [REG_AW-1:0] d, input bit [DATA_W-1:0] rr,
                       input bit [DATA_W-1:0] qq, input bit st, input bit fl);
    exp_t c;
    exp_t e;
    @(negedge clk);
    rst          = rs;
    bus.e_valid  = v;
    bus.ewreg    = w;
    bus.em2reg   = m2;
    bus.ewmem    = wm;
    bus.edestReg = d;
    bus.r        = rr;
    bus.eqb      = qq;
    bus.stall    = st;
    bus.flush    = fl;

    if (rs || fl) begin
      pipe_m.delete();
      for (int i = 0; i < STAGES; i++) pipe_m.push_back(zero_entry());
    end else if (!st) begin
      c       = zero_entry();
      c.valid = v;
      if (v) begin
        c.wreg  = w && (d != 0);
        c.m2reg = m2;
        c.wmem  = wm;
      end
      c.dest = d;
      c.r    = rr;
      c.qb   = qq;
      pipe_m.push_front(c);
      void'(pipe_m.pop_back());
    end

    if (rs) begin
      model_scnt = 0;
      model_bcnt = 0;
    end else begin
      if (st && !fl && model_scnt < CNT_MAX) model_scnt++;
      if ((fl || (!st && !v)) && model_bcnt < CNT_MAX) model_bcnt++;
    end

    e      = pipe_m[STAGES-1];
    e.scnt = model_scnt;
    e.bcnt = model_bcnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("m_valid",  longint'(bus.m_valid),  longint'(e.valid));
        check("mwreg",    longint'(bus.mwreg),    longint'(e.wreg));
        check("mm2reg",   longint'(bus.mm2reg),   longint'(e.m2reg));
        check("mwmem",    longint'(bus.mwmem),    longint'(e.wmem));
        check("mdestReg", longint'(bus.mdestReg), longint'(e.dest));
        check("mr",       longint'(bus.mr),       longint'(e.r));
        check("mqb",      longint'(bus.mqb),      longint'(e.qb));
`ifdef EXE_MEM_PERF_CNT_EN
        check("stall_cnt",  longint'(stall_cnt),  longint'(e.scnt));
        check("bubble_cnt", longint'(bubble_cnt), longint'(e.bcnt));
`endif
      end
    end
  end

  initial begin : stimulus
    int guard;
    for (int i = 0; i < STAGES; i++) pipe_m.push_back(zero_entry());

    // reset with every input nonzero, then first instruction
    drive(1, 1, 1, 1, 1, 5'd31, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1, 1);
    drive(1, 1, 1, 1, 1, 5'd31, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1, 0);
    drive(0, 1, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 0, 0);
    idle(STAGES);

    // $zero destination: write suppressed, m2reg kept
    drive(0, 1, 1, 1, 0, 5'd0, 32'h55, 32'h66, 0, 0);
    idle(STAGES);

    // stall hold: A, B, three stall cycles with new inputs, then release
    drive(0, 1, 1, 0, 0, 5'd1, 32'd1, 32'd10, 0, 0);
    drive(0, 1, 1, 0, 0, 5'd2, 32'd2, 32'd20, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 1, 5'd3, 32'd3, 32'd30, 1, 0);
    drive(0, 1, 1, 0, 1, 5'd3, 32'd3, 32'd30, 0, 0);
    idle(STAGES + 1);

    // flush and stall on the same edge, then a fresh instruction
    drive(0, 1, 1, 1, 1, 5'd7, 32'hDEAD, 32'hBEEF, 0, 0);
    drive(0, 1, 1, 1, 1, 5'd8, 32'hCAFE, 32'hF00D, 0, 0);
    drive(0, 1, 1, 1, 1, 5'd9, 32'h1111, 32'h2222, 1, 1);
    drive(0, 1, 0, 1, 1, 5'd4, 32'h4444, 32'h5555, 0, 0);
    idle(STAGES);

    // bubble: control bits dropped when e_valid is low
    drive(0, 0, 1, 1, 1, 5'd12, 32'h77, 32'h88, 0, 0);
    idle(STAGES);

    // counter saturation and clearing
    drive(1, 0, 0, 0, 0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 5'd6, 32'd6, 32'd6, 1, 0);
    drive(1, 0, 0, 0, 0, '0, '0, '0, 0, 0);
    drive(0, 1, 1, 0, 0, 5'd6, 32'd6, 32'd6, 0, 1);
    drive(0, 0, 1, 0, 1, 5'd6, 32'd6, 32'd6, 0, 0);
    drive(0, 1, 1, 0, 0, 5'd6, 32'd6, 32'd6, 1, 0);
    drive(1, 1, 1, 1, 1, 5'd6, 32'd6, 32'd6, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 3),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0) ? 5'd0 : REG_AW'($urandom),
            $urandom, $urandom,
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 8));
    end
    idle(STAGES);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) check("drain", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
